// File: rtl/seq_mag_comp.sv
// -----------------------------------------------------------------------------
// seq_mag_comp
//
// Bit-serial magnitude comparator. Two WIDTH-bit operands are compared one bit
// per clock, LSB first, through a single 1-bit compare cell. Each operation
// runs as either an unsigned compare or a two's-complement signed compare.
// A result takes WIDTH cycles. This is the small-area choice for wide operands.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      compare request, taken only while busy==0
//   signed_mode  in   1      1 = two's-complement, 0 = unsigned (taken with start)
//   a, b         in   WIDTH  operands, captured on an accepted start
//   busy         out  1      compare in progress
//   done         out  1      one-cycle pulse when l/e/g have just been updated
//   l, e, g      out  1      A<B / A==B / A>B, held until the next done
//   fsm_state    out  2      current controller state, for observation only
//
// Handshake: a start is accepted on any rising edge where start==1 and
// busy==0. That includes the done cycle, which lets compares run back to back.
// A start seen while busy==1 is dropped and has no side effects.
// -----------------------------------------------------------------------------
module seq_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g,
    output logic [1:0]       fsm_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        R_EQ = 2'd0,
        R_LT = 2'd1,
        R_GT = 2'd2
    } res_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               smode;
    logic [CNT_W-1:0]   cnt;
    res_t               res;
    res_t               res_next;
    logic               accept;
    logic               last_bit;

    assign accept   = start && (state != S_RUN);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // 1-bit compare cell. Operands are shifted right, so bit 0 of each
    // shift register is always the bit currently being compared. A difference
    // in a higher bit overrides whatever the lower bits decided. For a signed
    // compare the MSB is the sign bit, so its sense is inverted: a 1 there
    // marks the smaller operand.
    always_comb begin
        res_next = res;
        if (a_sh[0] != b_sh[0]) begin
            if (last_bit && smode) begin
                res_next = a_sh[0] ? R_LT : R_GT;
            end else begin
                res_next = a_sh[0] ? R_GT : R_LT;
            end
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controller next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, bit stepping and result registers.
    // l/e/g are written only on the last-bit edge, which is the same edge
    // that moves the controller into DONE. They stay stable at all other times.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            smode <= 1'b0;
            cnt   <= '0;
            res   <= R_EQ;
            l     <= 1'b0;
            e     <= 1'b0;
            g     <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            smode <= signed_mode;
            cnt   <= '0;
            res   <= R_EQ;
        end else if (state == S_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CNT_W'(1);
            res  <= res_next;
            if (last_bit) begin
                l <= (res_next == R_LT);
                e <= (res_next == R_EQ);
                g <= (res_next == R_GT);
            end
        end
    end

    // busy and done are decoded directly from the state register. Reset
    // therefore clears them as soon as it is asserted, and an aborted
    // operation can never produce a done.
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_seq_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_comp
//
// Directed test of seq_mag_comp at WIDTH=8 and at WIDTH=1. Expected results
// are worked out by hand from the operand values.
// -----------------------------------------------------------------------------
module tb_seq_mag_comp;

    logic       clk;
    logic       rst_n;

    // WIDTH = 8 instance
    logic       start8;
    logic       smode8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8, done8, l8, e8, g8;
    logic [1:0] st8;

    // WIDTH = 1 instance
    logic       start1;
    logic       smode1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1, done1, l1, e1, g1;
    logic [1:0] st1;

    int total = 0;
    int bad   = 0;

    seq_mag_comp #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .signed_mode (smode8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .l           (l8),
        .e           (e8),
        .g           (g8),
        .fsm_state   (st8)
    );

    seq_mag_comp #(.WIDTH(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start1),
        .signed_mode (smode1),
        .a           (a1),
        .b           (b1),
        .busy        (busy1),
        .done        (done1),
        .l           (l1),
        .e           (e1),
        .g           (g1),
        .fsm_state   (st1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for done on the 8-bit instance. The wait is bounded. Returns the
    // number of edges that passed, or 0 if done never came.
    task automatic wait_done8(input int limit, output int cyc);
        cyc = 0;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (done8) begin
                cyc = n;
                break;
            end
        end
    endtask

    // One full compare on the 8-bit instance. exp_leg is {l,e,g}.
    task automatic cmp8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input logic [2:0] exp_leg);
        int cyc;
        a8 = av; b8 = bv; smode8 = sm; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv; smode8 = ~sm;   // inputs are don't-care after accept
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        wait_done8(24, cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'd8);
        chk({tag, "_leg"}, 32'({l8, e8, g8}), 32'(exp_leg));
        tick();
        chk({tag, "_idle"}, 32'({busy8, done8, l8, e8, g8}), 32'({2'b00, exp_leg}));
    endtask

    initial begin
        int cyc;
        int seen;
        logic [2:0] w1_exp [8];

        rst_n  = 1'b0;
        start8 = 1'b0; smode8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; smode1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state
        tick(); tick();
        chk("rst8_outs", 32'({busy8, done8, l8, e8, g8}), 32'd0);
        chk("rst1_outs", 32'({busy1, done1, l1, e1, g1}), 32'd0);
        chk("rst8_state", 32'(st8), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic compares, {l,e,g}
        cmp8("u_3c_c3", 8'h3C, 8'hC3, 1'b0, 3'b100);   // 60 < 195
        cmp8("s_3c_c3", 8'h3C, 8'hC3, 1'b1, 3'b001);   // 60 > -61
        cmp8("u_a5_a5", 8'hA5, 8'hA5, 1'b0, 3'b010);
        cmp8("s_a5_a5", 8'hA5, 8'hA5, 1'b1, 3'b010);
        cmp8("s_80_7f", 8'h80, 8'h7F, 1'b1, 3'b100);   // -128 < 127
        cmp8("u_80_7f", 8'h80, 8'h7F, 1'b0, 3'b001);   // 128 > 127
        cmp8("s_ff_01", 8'hFF, 8'h01, 1'b1, 3'b100);   // -1 < 1
        cmp8("u_00_ff", 8'h00, 8'hFF, 1'b0, 3'b100);

        // Outputs stay put while idle
        tick(); tick();
        chk("hold_idle", 32'({done8, l8, e8, g8}), 32'b0100);

        // Start held through RUN with changing operands: the later starts are ignored.
        a8 = 8'h10; b8 = 8'h20; smode8 = 1'b0; start8 = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            smode8 = 1'($urandom_range(0, 1));
            if (!busy8) seen++;
            tick();
        end
        chk("held_busy", 32'(seen), 32'd0);
        chk("held_leg_stable", 32'({l8, e8, g8}), 32'b100);  // previous result still there
        a8 = 8'hFE; b8 = 8'h01; smode8 = 1'b1;                // junk at the last-bit edge
        tick();
        chk("held_done", 32'(done8), 32'd1);
        chk("held_leg", 32'({l8, e8, g8}), 32'b100);          // 0x10 < 0x20
        // Back-to-back start on the done cycle
        a8 = 8'h55; b8 = 8'h54; smode8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("b2b_accept", 32'({busy8, done8, l8, e8, g8}), 32'b10100);
        wait_done8(24, cyc);
        chk("b2b_lat", 32'(cyc), 32'd8);
        chk("b2b_leg", 32'({l8, e8, g8}), 32'b001);
        tick();

        // Reset partway through RUN
        a8 = 8'h00; b8 = 8'hFF; smode8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_busy_pre", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 32'({busy8, done8, l8, e8, g8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        cmp8("post_abort", 8'h01, 8'h02, 1'b1, 3'b100);

        // WIDTH=1, exhaustive over {a,b,signed_mode}. Signed: a 1 is -1.
        w1_exp[0] = 3'b010;  // a0 b0 u
        w1_exp[1] = 3'b010;  // a0 b0 s
        w1_exp[2] = 3'b100;  // a0 b1 u: 0 < 1
        w1_exp[3] = 3'b001;  // a0 b1 s: 0 > -1
        w1_exp[4] = 3'b001;  // a1 b0 u: 1 > 0
        w1_exp[5] = 3'b100;  // a1 b0 s: -1 < 0
        w1_exp[6] = 3'b010;  // a1 b1 u
        w1_exp[7] = 3'b010;  // a1 b1 s
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vb;
            vb = 3'(v);
            a1 = vb[2]; b1 = vb[1]; smode1 = vb[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk($sformatf("w1_busy_%0d", v), 32'(busy1), 32'd1);
            tick();
            chk($sformatf("w1_done_%0d", v), 32'(done1), 32'd1);
            chk($sformatf("w1_leg_%0d", v), 32'({l1, e1, g1}), 32'(w1_exp[v]));
            tick();
            chk($sformatf("w1_idle_%0d", v), 32'({busy1, done1}), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time limit in case something stalls
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
